// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM skid buffer.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Bit positions inside in_ctrl / out_ctrl.
    localparam int unsigned CTRL_REG_WR     = 3;
    localparam int unsigned CTRL_MEM_TO_REG = 2;
    localparam int unsigned CTRL_MEM_RD     = 1;
    localparam int unsigned CTRL_MEM_WR     = 0;

    localparam int unsigned DEF_PAYLOAD_W = 2 * 32 + 5 + 5;

    // res + zf + wdata + rd + ctrl(4)
    function automatic int unsigned payload_w(input int unsigned data_w, input int unsigned reg_w);
        return 2 * data_w + reg_w + 5;
    endfunction

endpackage

// File: rtl/ex_mem_stall_cnt.sv
// Saturating back-pressure cycle counter; only compiled when EX_MEM_STALL_CNT_EN is defined.
`ifdef EX_MEM_STALL_CNT_EN
module ex_mem_stall_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a one-entry skid buffer so in_ready depends on registered state only.
// Optional back-pressure counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_res,
    input  logic              in_zf,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [3:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic              out_zf,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_rd,
    output logic [3:0]        out_ctrl,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PW = payload_w(DATA_W, REG_W);

    state_t          state_q, state_d;
    logic [PW-1:0]   in_pl, main_q, skid_q;
    logic            accept, pop;
    logic            load_main, main_from_skid, load_skid;

    assign in_pl     = {in_res, in_zf, in_wdata, in_rd, in_ctrl};
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign {out_res, out_zf, out_wdata, out_rd, out_ctrl} = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush empties the buffer but leaves payload registers untouched.
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_pl;
            end
            if (load_skid) begin
                skid_q <= in_pl;
            end
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    ex_mem_stall_cnt #(
        .WIDTH(16)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_valid & ~out_ready),
        .cnt  (stall_cnt)
    );
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenarios plus a randomized run against a queue model.
module tb_ex_mem_skid;
    import ex_mem_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned PW = 2 * DW + RW + 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_res;
    logic          in_zf;
    logic [DW-1:0] in_wdata;
    logic [RW-1:0] in_rd;
    logic [3:0]    in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_res;
    logic          out_zf;
    logic [DW-1:0] out_wdata;
    logic [RW-1:0] out_rd;
    logic [3:0]    out_ctrl;
    logic [15:0]   stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO of at most two payloads plus a saturating stall count.
    logic [PW-1:0] q[$];
    logic [15:0]   stall_m;

    ex_mem_skid #(
        .DATA_W(DW),
        .REG_W (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_res   (in_res),
        .in_zf    (in_zf),
        .in_wdata (in_wdata),
        .in_rd    (in_rd),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_zf   (out_zf),
        .out_wdata(out_wdata),
        .out_rd   (out_rd),
        .out_ctrl (out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] mk(input logic [DW-1:0] r, input logic z,
                                         input logic [DW-1:0] w, input logic [RW-1:0] rd,
                                         input logic [3:0] c);
        return {r, z, w, rd, c};
    endfunction

    function automatic logic [PW-1:0] rnd_pl();
        return mk($urandom, 1'($urandom), $urandom, 5'($urandom), 4'($urandom));
    endfunction

    function automatic logic [PW-1:0] out_pl();
        return {out_res, out_zf, out_wdata, out_rd, out_ctrl};
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef EX_MEM_STALL_CNT_EN
        return stall_m;
`else
        return 16'h0000;
`endif
    endfunction

    // Drive one cycle's inputs, advance the model at the edge, return at the next negedge.
    task automatic do_cycle(input logic iv, input logic [PW-1:0] pl, input logic ordy, input logic fl);
        logic acc, pp;
        in_valid  = iv;
        {in_res, in_zf, in_wdata, in_rd, in_ctrl} = pl;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        acc = iv && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy && (stall_m != 16'hFFFF)) stall_m = stall_m + 16'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(pl);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        q.delete();
        stall_m = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        {in_res, in_zf, in_wdata, in_rd, in_ctrl} = '0;
        q.delete();
        stall_m = '0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_pl() !== '0) begin fails++; $display("FAIL reset_payload: got %h expected 0", out_pl()); end
        tests++; if (stall_cnt !== 16'h0) begin fails++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_accept();
        do_cycle(1'b1, mk(32'h0000_0005, 1'b0, '0, '0, 4'b1000), 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL first_out_valid: got %b expected 1", out_valid); end
        tests++; if (out_res !== 32'h5) begin fails++; $display("FAIL first_out_res: got %h expected 5", out_res); end
        tests++; if (out_ctrl[CTRL_REG_WR] !== 1'b1 || out_ctrl !== 4'b1000) begin
            fails++; $display("FAIL first_out_ctrl: got %b expected 1000", out_ctrl);
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL first_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        logic [PW-1:0] a, b, c;
        a = rnd_pl(); b = rnd_pl(); c = rnd_pl();
        do_cycle(1'b1, a, 1'b0, 1'b0);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_after_a: got %b expected 1", in_ready); end
        do_cycle(1'b1, b, 1'b0, 1'b0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_at_c: got %b expected 0", in_ready); end
        do_cycle(1'b1, c, 1'b0, 1'b0);
        tests++; if (out_pl() !== a) begin fails++; $display("FAIL fill_hold_a: got %h expected %h", out_pl(), a); end
        do_cycle(1'b1, c, 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b1 || out_pl() !== b) begin
            fails++; $display("FAIL drain_b: got %b/%h expected 1/%h", out_valid, out_pl(), b);
        end
        do_cycle(1'b1, c, 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b1 || out_pl() !== c) begin
            fails++; $display("FAIL drain_c: got %b/%h expected 1/%h", out_valid, out_pl(), c);
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [PW-1:0] a, b;
        a = rnd_pl(); b = rnd_pl();
        do_cycle(1'b1, a, 1'b0, 1'b0);
        do_cycle(1'b1, b, 1'b0, 1'b0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_full: got in_ready %b expected 0", in_ready); end
        do_cycle(1'b1, rnd_pl(), 1'b1, 1'b1);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_state: got valid %b ready %b expected 0/1", out_valid, in_ready);
        end
        tests++; if (out_pl() !== a) begin fails++; $display("FAIL flush_payload_hold: got %h expected %h", out_pl(), a); end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, '0, 1'b1, 1'b0);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_emit: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p;
        for (int i = 0; i < 8; i++) begin
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            p = rnd_pl();
            do_cycle(1'b1, p, 1'b1, 1'b0);
            tests++; if (out_valid !== 1'b1 || out_pl() !== p) begin
                fails++; $display("FAIL b2b_out[%0d]: got %b/%h expected 1/%h", i, out_valid, out_pl(), p);
            end
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] d;
        do_cycle(1'b1, rnd_pl(), 1'b0, 1'b0);
        do_cycle(1'b1, rnd_pl(), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        stall_m = '0;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL async_reset: got valid %b ready %b expected 0/1", out_valid, in_ready);
        end
        tests++; if (out_pl() !== '0) begin fails++; $display("FAIL async_reset_payload: got %h expected 0", out_pl()); end
        @(negedge clk);
        rst_n = 1'b1;
        d = rnd_pl();
        do_cycle(1'b1, d, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || out_pl() !== d || in_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset_accept: got %b/%b/%h expected 1/1/%h", out_valid, in_ready, out_pl(), d);
        end
    endtask

    task automatic test_stall_cnt();
        apply_reset();
        do_cycle(1'b1, rnd_pl(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, '0, 1'b0, 1'b0);
`ifdef EX_MEM_STALL_CNT_EN
        tests++; if (stall_cnt !== 16'd10) begin fails++; $display("FAIL stall_cnt_10: got %0d expected 10", stall_cnt); end
`else
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stall_cnt_off: got %0d expected 0", stall_cnt); end
`endif
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        tests++; if (stall_cnt !== exp_stall()) begin
            fails++; $display("FAIL stall_cnt_hold: got %0d expected %0d", stall_cnt, exp_stall());
        end
    endtask

    task automatic test_random();
        logic iv, ordy, fl;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            tests++; if (out_valid !== logic'(q.size() > 0)) begin
                fails++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, q.size() > 0);
            end
            tests++; if (in_ready !== logic'(q.size() < 2)) begin
                fails++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, q.size() < 2);
            end
            if (q.size() > 0) begin
                tests++; if (out_pl() !== q[0]) begin
                    fails++; $display("FAIL rnd_payload[%0d]: got %h expected %h", i, out_pl(), q[0]);
                end
            end
            tests++; if (stall_cnt !== exp_stall()) begin
                fails++; $display("FAIL rnd_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_stall());
            end
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(1) != 0);
            fl   = ($urandom_range(19) == 0);
            do_cycle(iv, rnd_pl(), ordy, fl);
        end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_fill_drain();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_stall_cnt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
